// File: rtl/mux_sync_multi.sv
// -----------------------------------------------------------------------------
// mux_sync_multi
//
// Multi-channel, enable-qualified capture of quasi-static buses into the
// sync_clk domain. Each channel has an asynchronous enable. The enable passes
// through a SYNC_STAGE-deep synchroniser. The synchronised enable, taken either
// as a level or as a rising edge, qualifies a capture of that channel's lane.
// The lane can optionally be Gray-decoded before capture. Each captured value
// is offered downstream with a valid/ready handshake and a sticky overflow flag.
//
// Ports:
//   sync_clk    in   1                  sole clock
//   sync_rstn   in   1                  synchronous active-low reset
//   data_in     in   NUM_CH*DATA_WIDTH  lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_en     in   NUM_CH             per-channel asynchronous enable
//   dout_ready  in   NUM_CH             per-channel consumer ready
//   ovf_clr     in   1                  clears every dout_ovf bit
//   dataout     out  NUM_CH*DATA_WIDTH  captured data, same lane packing
//   dout_valid  out  NUM_CH             captured data pending
//   dout_ovf    out  NUM_CH             sticky: unconsumed data was overwritten
//
// Handshake: dout_valid[c] rises when a value is captured. It stays high until
// an edge where dout_ready[c]=1 and no new capture happens. A capture always
// loads the lane. If a capture lands while valid=1 and ready=0, it overwrites
// unread data and sets dout_ovf[c]. Ready is ignored while valid is low.
// -----------------------------------------------------------------------------
module mux_sync_multi #(
   parameter int                    NUM_CH       = 4,
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    SYNC_STAGE   = 2,
   parameter int                    CAPTURE_MODE = 1,
   parameter int                    GRAY_IN      = 0,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE    = '0
) (
   input  logic                         sync_clk,
   input  logic                         sync_rstn,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_CH-1:0]            data_en,
   input  logic [NUM_CH-1:0]            dout_ready,
   input  logic                         ovf_clr,
   output logic [NUM_CH*DATA_WIDTH-1:0] dataout,
   output logic [NUM_CH-1:0]            dout_valid,
   output logic [NUM_CH-1:0]            dout_ovf
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [SYNC_STAGE-1:0] r_sync;
      logic                  w_en_sync;
      logic                  w_cap;
      logic [DATA_WIDTH-1:0] w_lane_raw;
      logic [DATA_WIDTH-1:0] w_lane_bin;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_valid;
      logic                  r_ovf;

      assign w_lane_raw = data_in[c*DATA_WIDTH +: DATA_WIDTH];

      // Enable synchroniser: bit 0 samples the asynchronous input.
      always_ff @(posedge sync_clk) begin
         if (!sync_rstn) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGE-2:0], data_en[c]};
         end
      end

      assign w_en_sync = r_sync[SYNC_STAGE-1];

      if (CAPTURE_MODE == 1) begin : g_edge
         logic r_en_prev;

         always_ff @(posedge sync_clk) begin
            if (!sync_rstn) begin
               r_en_prev <= 1'b0;
            end else begin
               r_en_prev <= w_en_sync;
            end
         end

         assign w_cap = w_en_sync & ~r_en_prev;
      end else begin : g_level
         assign w_cap = w_en_sync;
      end

      if (GRAY_IN == 1) begin : g_gray
         // Binary bit i is the XOR of all Gray bits at or above position i.
         always_comb begin
            w_lane_bin = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
               w_lane_bin[i] = ^(w_lane_raw >> i);
            end
         end
      end else begin : g_plain
         assign w_lane_bin = w_lane_raw;
      end

      always_ff @(posedge sync_clk) begin
         if (!sync_rstn) begin
            r_data  <= RST_VALUE;
            r_valid <= 1'b0;
         end else if (w_cap) begin
            r_data  <= w_lane_bin;
            r_valid <= 1'b1;
         end else if (dout_ready[c]) begin
            r_valid <= 1'b0;
         end
      end

      // A new overflow on this edge takes priority over a global clear.
      always_ff @(posedge sync_clk) begin
         if (!sync_rstn) begin
            r_ovf <= 1'b0;
         end else if (w_cap && r_valid && !dout_ready[c]) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end

      assign dataout[c*DATA_WIDTH +: DATA_WIDTH] = r_data;
      assign dout_valid[c]                       = r_valid;
      assign dout_ovf[c]                         = r_ovf;
   end

endmodule

// File: tb/tb_mux_sync_multi.sv
// -----------------------------------------------------------------------------
// tb_mux_sync_multi
//
// Directed bench for mux_sync_multi with two channels of 4 bits and a 2-stage
// synchroniser. dut_e runs in edge mode with plain data. dut_g runs in level
// mode with Gray-decoded data. Inputs change 1 time unit after a rising edge.
// Outputs are checked at the same point, so every check sees the state that
// the preceding edge registered.
// -----------------------------------------------------------------------------
module tb_mux_sync_multi;

   logic       clk;
   logic       rstn;

   logic [7:0] e_data;
   logic [1:0] e_en;
   logic [1:0] e_rdy;
   logic       e_clr;
   logic [7:0] e_dout;
   logic [1:0] e_valid;
   logic [1:0] e_ovf;

   logic [7:0] g_data;
   logic [1:0] g_en;
   logic [1:0] g_rdy;
   logic       g_clr;
   logic [7:0] g_dout;
   logic [1:0] g_valid;
   logic [1:0] g_ovf;

   int checks = 0;
   int errors = 0;

   mux_sync_multi #(
      .NUM_CH(2), .DATA_WIDTH(4), .SYNC_STAGE(2),
      .CAPTURE_MODE(1), .GRAY_IN(0), .RST_VALUE(4'h0)
   ) dut_e (
      .sync_clk(clk), .sync_rstn(rstn), .data_in(e_data), .data_en(e_en),
      .dout_ready(e_rdy), .ovf_clr(e_clr), .dataout(e_dout),
      .dout_valid(e_valid), .dout_ovf(e_ovf)
   );

   mux_sync_multi #(
      .NUM_CH(2), .DATA_WIDTH(4), .SYNC_STAGE(2),
      .CAPTURE_MODE(0), .GRAY_IN(1), .RST_VALUE(4'h0)
   ) dut_g (
      .sync_clk(clk), .sync_rstn(rstn), .data_in(g_data), .data_en(g_en),
      .dout_ready(g_rdy), .ovf_clr(g_clr), .dataout(g_dout),
      .dout_valid(g_valid), .dout_ovf(g_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Enable sampled at two consecutive edges (k, k+1), then dropped. After
   // this returns, the next tick is the capture edge k+2.
   task automatic pulse_e(input logic [1:0] mask, input logic [7:0] data);
      e_data = data;
      e_en   = mask;
      tick();
      tick();
      e_en   = 2'b00;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      e_en = 2'b11;
      g_en = 2'b11;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (e_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dataout: got %h expected 00", e_dout);
         end
         checks++;
         if (e_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 00", e_valid);
         end
         checks++;
         if (e_ovf !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 00", e_ovf);
         end
      end
      g_en = 2'b00;
      rstn = 1'b1;
      tick();  // edge k: first sample of the enable
      tick();  // edge k+1: synced enable rises
      checks++;
      if (e_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_early: got %b expected 00", e_valid);
      end
      tick();  // edge k+2: capture
      checks++;
      if (e_valid !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_valid: got %b expected 11", e_valid);
      end
      // Drain and idle.
      e_en  = 2'b00;
      e_rdy = 2'b11;
      for (int i = 0; i < 4; i++) tick();
      e_rdy = 2'b00;
      checks++;
      if (e_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_drain: got %b expected 00", e_valid);
      end
   endtask

   task automatic test_edge_capture();
      e_data = 8'h09;
      e_en   = 2'b01;
      tick();  // k
      tick();  // k+1
      checks++;
      if (e_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL edge_latency: valid0 got %b expected 0", e_valid[0]);
      end
      tick();  // k+2
      checks++;
      if (e_valid[0] !== 1'b1 || e_dout[3:0] !== 4'h9) begin
         errors++;
         $display("FAIL edge_capture: valid0=%b data0=%h expected 1/9", e_valid[0], e_dout[3:0]);
      end
      tick();  // k+3
      tick();  // k+4: enable sampled for the fifth edge
      e_en = 2'b00;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (e_valid[0] !== 1'b1 || e_ovf[0] !== 1'b0 || e_dout[3:0] !== 4'h9) begin
         errors++;
         $display("FAIL edge_single: valid0=%b ovf0=%b data0=%h expected 1/0/9",
                  e_valid[0], e_ovf[0], e_dout[3:0]);
      end
   endtask

   task automatic test_overflow();
      pulse_e(2'b01, 8'h03);
      tick();
      checks++;
      if (e_dout[3:0] !== 4'h3 || e_ovf[0] !== 1'b1 || e_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: data0=%h ovf0=%b valid0=%b expected 3/1/1",
                  e_dout[3:0], e_ovf[0], e_valid[0]);
      end
      e_clr = 1'b1;
      tick();
      e_clr = 1'b0;
      checks++;
      if (e_ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b expected 0", e_ovf[0]);
      end
      tick();
      tick();
      // Overflow and clear on the same edge: overflow wins.
      pulse_e(2'b01, 8'h0C);
      e_clr = 1'b1;
      tick();
      e_clr = 1'b0;
      checks++;
      if (e_ovf[0] !== 1'b1 || e_dout[3:0] !== 4'hC) begin
         errors++;
         $display("FAIL ovf_vs_clear: ovf0=%b data0=%h expected 1/c", e_ovf[0], e_dout[3:0]);
      end
      e_clr = 1'b1;
      e_rdy = 2'b01;
      tick();
      e_clr = 1'b0;
      e_rdy = 2'b00;
      checks++;
      if (e_valid[0] !== 1'b0 || e_ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drain: valid0=%b ovf0=%b expected 0/0", e_valid[0], e_ovf[0]);
      end
      tick();
      tick();
   endtask

   task automatic test_ready_same_cycle();
      pulse_e(2'b10, 8'h50);
      tick();
      checks++;
      if (e_valid[1] !== 1'b1 || e_dout[7:4] !== 4'h5) begin
         errors++;
         $display("FAIL ready_first: valid1=%b data1=%h expected 1/5", e_valid[1], e_dout[7:4]);
      end
      tick();
      tick();
      pulse_e(2'b10, 8'hA0);
      e_rdy = 2'b10;
      tick();
      checks++;
      if (e_valid[1] !== 1'b1 || e_dout[7:4] !== 4'hA || e_ovf[1] !== 1'b0) begin
         errors++;
         $display("FAIL ready_same: valid1=%b data1=%h ovf1=%b expected 1/a/0",
                  e_valid[1], e_dout[7:4], e_ovf[1]);
      end
      tick();
      e_rdy = 2'b00;
      checks++;
      if (e_valid[1] !== 1'b0 || e_dout[7:4] !== 4'hA) begin
         errors++;
         $display("FAIL ready_consume: valid1=%b data1=%h expected 0/a", e_valid[1], e_dout[7:4]);
      end
      tick();
      tick();
   endtask

   task automatic test_gray_level();
      g_data = 8'b0000_1101;
      g_rdy  = 2'b11;
      g_en   = 2'b01;
      tick();  // k
      tick();  // k+1
      checks++;
      if (g_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL gray_latency: valid0 got %b expected 0", g_valid[0]);
      end
      tick();  // k+2: enable sampled at k, k+1, k+2
      g_en = 2'b00;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (g_valid[0] !== 1'b1 || g_dout[3:0] !== 4'b1001 || g_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL gray_level_cycle%0d: valid0=%b data0=%b ovf0=%b expected 1/1001/0",
                     i, g_valid[0], g_dout[3:0], g_ovf[0]);
         end
         tick();
      end
      checks++;
      if (g_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL gray_level_end: valid0 got %b expected 0", g_valid[0]);
      end
      // Level mode with no ready: the second consecutive capture overflows.
      g_rdy  = 2'b00;
      g_data = 8'b0000_0110;  // Gray 0110 decodes to binary 0100
      g_en   = 2'b01;
      tick();
      tick();
      g_en = 2'b00;
      tick();
      checks++;
      if (g_ovf[0] !== 1'b0 || g_dout[3:0] !== 4'b0100) begin
         errors++;
         $display("FAIL gray_first_noready: ovf0=%b data0=%b expected 0/0100", g_ovf[0], g_dout[3:0]);
      end
      tick();
      checks++;
      if (g_ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL level_ovf: got %b expected 1", g_ovf[0]);
      end
   endtask

   task automatic test_independence();
      e_data = 8'hF1;
      e_en   = 2'b11;
      tick();
      tick();
      checks++;
      if (e_valid !== 2'b00) begin
         errors++;
         $display("FAIL indep_latency: got %b expected 00", e_valid);
      end
      e_en = 2'b00;
      tick();
      checks++;
      if (e_valid !== 2'b11 || e_dout !== 8'hF1) begin
         errors++;
         $display("FAIL indep_both: valid=%b data=%h expected 11/f1", e_valid, e_dout);
      end
      // Reset while a second capture is still in the synchroniser.
      e_data = 8'h5A;
      e_en   = 2'b11;
      tick();
      rstn = 1'b0;
      tick();
      checks++;
      if (e_valid !== 2'b00 || e_dout !== 8'h00 || e_ovf !== 2'b00) begin
         errors++;
         $display("FAIL indep_reset: valid=%b data=%h ovf=%b expected 00/00/00",
                  e_valid, e_dout, e_ovf);
      end
      checks++;
      if (g_ovf !== 2'b00 || g_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_level_dut: valid=%b ovf=%b expected 00/00", g_valid, g_ovf);
      end
      e_en = 2'b00;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (e_valid !== 2'b00 || e_dout !== 8'h00) begin
         errors++;
         $display("FAIL indep_discard: valid=%b data=%h expected 00/00", e_valid, e_dout);
      end
   endtask

   initial begin
      rstn   = 1'b0;
      e_data = 8'h00;
      e_en   = 2'b00;
      e_rdy  = 2'b00;
      e_clr  = 1'b0;
      g_data = 8'h00;
      g_en   = 2'b00;
      g_rdy  = 2'b00;
      g_clr  = 1'b0;
      #1;
      test_reset();
      test_edge_capture();
      test_overflow();
      test_ready_same_cycle();
      test_gray_level();
      test_independence();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
